cnt_timer_ctrl: RTL and testbench
=================================

// Module: cnt_timer_ctrl
// PURPOSE
//  Sequencing controller for the n-bit up-counter datapath. Turns it into a programmable timer:
//  start/stop/pause control, a latched terminal value, and one-shot or periodic reload.
//  Raises a one-cycle done pulse at terminal count.
//  Sits between firmware-style control strobes and any logic needing timed events.
// PARAMETERS
//  CNT_WIDTH  8  width of counter, term_val and internal terminal latch
//  PRE_WIDTH  4  prescaler width; used only when CNT_PRESCALER_EN is defined
// PORTS
//  clk       in   1          single clock, all state updates on posedge
//  reset_n   in   1          asynchronous, active-low reset
//  start     in   1          1-cycle strobe: latch config, clear count, run
//  stop      in   1          1-cycle strobe: abort to IDLE
//  pause     in   1          level: freeze count while high (RUN<->HOLD)
//  periodic  in   1          sampled with start: 1=auto-reload, 0=one-shot
//  term_val  in   CNT_WIDTH  terminal count, sampled with start
//  prescale  in   PRE_WIDTH  tick divider, present only with CNT_PRESCALER_EN
//  counter   out  CNT_WIDTH  current count (registered)
//  busy      out  1          1 in RUN or HOLD (registered)
//  done      out  1          1-cycle pulse at terminal count (registered)
//  state     out  2          IDLE=00 RUN=01 HOLD=10 DONE=11
// BEHAVIOUR
//  - Reset (async, immediate, any state): state=IDLE, counter=0, busy=0, done=0; latches=0.
//  - All outputs are registered. No combinational input->output paths.
//  - Command priority each edge: stop > start > pause.
//  - stop (any state): next state IDLE, counter=0, done=0. A pending terminal event is dropped.
//  - start (any state, stop=0): latch term_val and periodic, counter=0, next state RUN,
//    prescaler cleared. Restart from RUN/HOLD is legal.
//  - tick = 1 every cycle without the macro; see CONFIGURATION.
//  - RUN, pause=0, tick:
//      - counter != term_lat: counter+1.
//      - counter == term_lat: done=1 for exactly one cycle.
//        - periodic: counter=0, stay RUN.
//        - one-shot: counter holds term_lat, state=DONE.
//  - RUN with pause=1 -> HOLD. HOLD with pause=0 -> RUN.
//    In HOLD the counter and prescaler are frozen and ticks are discarded.
//  - DONE: counter holds, busy=0. Only start or stop leave DONE.
//  - IDLE: counter=0, busy=0. pause ignored.
//  - Period = term_lat+1 ticks. term_val=0 gives done on first tick after start
//    (every tick if periodic).
//  - Counter is unsigned and never exceeds term_lat, so no modulo wrap occurs.
//    term_val=2^CNT_WIDTH-1 is legal.
//  - Terminal and start in the same cycle: start wins (counter=0, relatch), done still pulses.
//  - Terminal and stop in the same cycle: stop wins, no done.
//  - Changing term_val/periodic mid-run has no effect until the next start.
// CONFIGURATION
//  CNT_PRESCALER_EN defined:
//    - Adds port prescale and a PRE_WIDTH-bit divider.
//    - tick asserts once every prescale+1 cycles of RUN (prescale=0 -> every cycle).
//    - prescale is sampled with start.
//    - Divider is cleared on start and stop, and frozen in HOLD.
//  CNT_PRESCALER_EN undefined:
//    - No prescale port, no divider logic.
//    - tick=1 every cycle; PRE_WIDTH unused.
// TESTING
//  T1 reset:
//     assert reset_n=0 mid-RUN at counter=4
//     -> same instant: counter=0, state=00, busy=0, done=0
//     -> after release, stays IDLE until start.
//  T2 one-shot, term_val=5, periodic=0, 1-cycle start:
//     -> counter 0,1,2,3,4,5 on successive edges
//     -> done=1 for one cycle 6 edges after RUN entry
//     -> state=11, counter holds 5, busy=0.
//  T3 periodic, term_val=3:
//     -> counter 0,1,2,3,0,1..., done pulses every 4 cycles, busy stays 1, state stays 01.
//  T4 pause, term_val=5 one-shot, pause=1 for 3 cycles at counter=2:
//     -> state=10, counter frozen at 2
//     -> resumes 3,4,5; done 3 cycles later than T2.
//  T5 simultaneous commands:
//     stop+start same cycle in RUN -> IDLE, counter=0, no done
//     start at terminal cycle -> done pulses, counter=0, RUN with new term.
//  T6 [CNT_PRESCALER_EN] prescale=2, term_val=2:
//     -> counter steps every 3 cycles, done 9 cycles after RUN entry
//     -> pause freezes divider phase.

Source files
------------

// File: rtl/cnt_timer_ctrl.sv
// Programmable timer controller around an n-bit up-counter: start/stop/pause, latched terminal
// value, one-shot or periodic reload, one-cycle done pulse. Optional divider: CNT_PRESCALER_EN.
module cnt_timer_ctrl #(
    parameter int CNT_WIDTH = 8,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 periodic,
    input  logic [CNT_WIDTH-1:0] term_val,
`ifdef CNT_PRESCALER_EN
    input  logic [PRE_WIDTH-1:0] prescale,
`endif
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_counter;
    logic [CNT_WIDTH-1:0] r_term_lat;
    logic                 r_periodic;
    logic                 r_done;
    logic                 r_busy;

    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] w_counter_nxt;
    logic [CNT_WIDTH-1:0] w_term_nxt;
    logic                 w_periodic_nxt;
    logic                 w_done_nxt;
    logic                 w_active;
    logic                 w_tick;
    logic                 w_terminal;

    // A cycle counts when the timer is armed and not paused; leaving HOLD counts too,
    // so a pause costs exactly as many cycles as it was held high.
    assign w_active   = ((r_state == S_RUN) || (r_state == S_HOLD)) && !pause;
    assign w_terminal = w_active && w_tick && (r_counter == r_term_lat);

`ifdef CNT_PRESCALER_EN
    logic [PRE_WIDTH-1:0] r_pre_cnt;
    logic [PRE_WIDTH-1:0] r_pre_lat;

    localparam logic [PRE_WIDTH-1:0] LP_PRE_ONE = PRE_WIDTH'(1);

    assign w_tick = (r_pre_cnt == r_pre_lat);

    // Divider phase only advances on counting cycles, so HOLD freezes it in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre_cnt <= '0;
            r_pre_lat <= '0;
        end else if (stop) begin
            r_pre_cnt <= '0;
        end else if (start) begin
            r_pre_cnt <= '0;
            r_pre_lat <= prescale;
        end else if (w_active) begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + LP_PRE_ONE;
        end
    end
`else
    localparam logic [PRE_WIDTH-1:0] LP_PRE_ZERO = '0;

    assign w_tick = (LP_PRE_ZERO == '0);
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_nxt    = r_state;
        w_counter_nxt  = r_counter;
        w_term_nxt     = r_term_lat;
        w_periodic_nxt = r_periodic;
        w_done_nxt     = 1'b0;

        if (stop) begin
            w_state_nxt   = S_IDLE;
            w_counter_nxt = '0;
        end else if (start) begin
            w_state_nxt    = S_RUN;
            w_counter_nxt  = '0;
            w_term_nxt     = term_val;
            w_periodic_nxt = periodic;
            w_done_nxt     = w_terminal;
        end else begin
            unique case (r_state)
                S_RUN, S_HOLD: begin
                    if (pause) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_RUN;
                        if (w_terminal) begin
                            w_done_nxt = 1'b1;
                            if (r_periodic) begin
                                w_counter_nxt = '0;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else if (w_tick) begin
                            w_counter_nxt = r_counter + LP_CNT_ONE;
                        end
                    end
                end
                S_IDLE: w_counter_nxt = '0;
                S_DONE: w_state_nxt   = S_DONE;
                default: w_state_nxt  = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_counter  <= '0;
            r_term_lat <= '0;
            r_periodic <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_counter  <= w_counter_nxt;
            r_term_lat <= w_term_nxt;
            r_periodic <= w_periodic_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
        end
    end

    assign counter = r_counter;
    assign busy    = r_busy;
    assign done    = r_done;
    assign state   = r_state;

endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// Directed self-checking bench for cnt_timer_ctrl; prescaler case runs when CNT_PRESCALER_EN is defined.
module tb_cnt_timer_ctrl;

    localparam int CW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, stop, pause, periodic;
    logic [CW-1:0] term_val;
`ifdef CNT_PRESCALER_EN
    logic [PW-1:0] prescale;
`endif
    logic [CW-1:0] counter;
    logic          busy, done;
    logic [1:0]    state;

    int n_vec = 0;
    int n_err = 0;

    localparam int IDLE = 0, RUN = 1, HOLD = 2, DN = 3;

    cnt_timer_ctrl #(.CNT_WIDTH(CW), .PRE_WIDTH(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .term_val (term_val),
`ifdef CNT_PRESCALER_EN
        .prescale (prescale),
`endif
        .counter  (counter),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int cnt, input int st, input int b, input int d);
        check({tag, ".counter"}, 32'(counter), cnt);
        check({tag, ".state"},   32'(state),   st);
        check({tag, ".busy"},    32'(busy),    b);
        check({tag, ".done"},    32'(done),    d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle start; on return the start edge has passed.
    task automatic do_start(input int tv, input bit per);
        start    = 1'b1;
        term_val = CW'(tv);
        periodic = per;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pause    = 1'b0;
        periodic = 1'b0;
        term_val = '0;
`ifdef CNT_PRESCALER_EN
        prescale = '0;
`endif
        repeat (3) step();
        expect_out("por", 0, IDLE, 0, 0);
        reset_n = 1'b1;
        step();
        expect_out("idle_after_por", 0, IDLE, 0, 0);

        // T2 one-shot term=5; term_val change mid-run must be ignored
        do_start(5, 1'b0);
        term_val = 8'd9;
        periodic = 1'b1;
        expect_out("t2.e0", 0, RUN, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            expect_out($sformatf("t2.e%0d", k), k, RUN, 1, 0);
        end
        step();
        expect_out("t2.term", 5, DN, 0, 1);
        step();
        expect_out("t2.hold", 5, DN, 0, 0);
        pause = 1'b1;
        step();
        expect_out("t2.done_ignores_pause", 5, DN, 0, 0);
        pause = 1'b0;

        // T1 async reset mid-run at counter=4
        do_start(10, 1'b0);
        repeat (4) step();
        check("t1.pre_reset_cnt", 32'(counter), 4);
        reset_n = 1'b0;
        #1;
        expect_out("t1.async", 0, IDLE, 0, 0);
        #3;
        reset_n = 1'b1;
        repeat (3) step();
        expect_out("t1.stays_idle", 0, IDLE, 0, 0);
        pause = 1'b1;
        step();
        expect_out("idle_ignores_pause", 0, IDLE, 0, 0);
        pause = 1'b0;

        // T3 periodic term=3
        do_start(3, 1'b1);
        expect_out("t3.e0", 0, RUN, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            expect_out($sformatf("t3.e%0d", k), k % 4, RUN, 1, (k % 4 == 0) ? 1 : 0);
        end
        do_stop();
        expect_out("t3.stop", 0, IDLE, 0, 0);

        // T4 pause for 3 cycles at counter=2
        do_start(5, 1'b0);
        step();
        step();
        check("t4.before_pause", 32'(counter), 2);
        pause = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            step();
            expect_out($sformatf("t4.hold%0d", k), 2, HOLD, 1, 0);
        end
        pause = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            step();
            expect_out($sformatf("t4.e%0d", k), k - 3, RUN, 1, 0);
        end
        step();
        expect_out("t4.term", 5, DN, 0, 1);

        // T5a stop+start together in RUN
        do_start(7, 1'b1);
        repeat (3) step();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        expect_out("t5.stop_start", 0, IDLE, 0, 0);
        step();
        expect_out("t5.stop_start_next", 0, IDLE, 0, 0);

        // T5b start on the terminal cycle: done pulses, new term 4 latched
        do_start(2, 1'b0);
        step();
        step();
        do_start(4, 1'b0);
        expect_out("t5.start_at_term", 0, RUN, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            expect_out($sformatf("t5.new_e%0d", k), k, RUN, 1, 0);
        end
        step();
        expect_out("t5.new_term", 4, DN, 0, 1);

        // T5c stop on the terminal cycle: no done
        do_start(1, 1'b0);
        step();
        do_stop();
        expect_out("t5.stop_at_term", 0, IDLE, 0, 0);

        // term_val=0 periodic: done on every tick
        do_start(0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            expect_out($sformatf("zero.e%0d", k), 0, RUN, 1, 1);
        end
        do_stop();

        // term_val=255 one-shot: full range, no wrap
        do_start(255, 1'b0);
        repeat (255) step();
        expect_out("max.e255", 255, RUN, 1, 0);
        step();
        expect_out("max.term", 255, DN, 0, 1);

`ifdef CNT_PRESCALER_EN
        // T6 prescale=2 term=2: counter steps every 3 cycles, done at edge 9
        prescale = 4'd2;
        do_start(2, 1'b0);
        prescale = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_out($sformatf("t6.e%0d", k), k / 3, RUN, 1, 0);
        end
        step();
        expect_out("t6.term", 2, DN, 0, 1);

        // divider phase is frozen through HOLD
        prescale = 4'd2;
        do_start(2, 1'b0);
        step();
        pause = 1'b1;
        step();
        step();
        expect_out("t6.hold", 0, HOLD, 1, 0);
        pause = 1'b0;
        step();
        expect_out("t6.resume", 0, RUN, 1, 0);
        step();
        expect_out("t6.phase_kept", 1, RUN, 1, 0);
        do_stop();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
